conv_output_writer: RTL

// Accelerator-side end of the shared C bus. Accepts finished output words from the PE array,

---
 rtl/conv_output_writer_if.sv | 41 ++++
 rtl/conv_output_writer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/conv_output_writer_if.sv
// Handshake and status bundle between conv_output_writer and its neighbours.
// The shared C bus itself stays a plain inout port on the block.
interface conv_output_writer_if #(
   parameter int DATA_WIDTH         = 16,
   parameter int FEATURE_MAP_WIDTH  = 128,
   parameter int FEATURE_MAP_HEIGHT = 128,
   parameter int OUTPUT_NB_CHANNELS = 64
);
   localparam int XW = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1;
   localparam int YW = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1;
   localparam int CW = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1;

   logic                  start;
   logic [1:0]            conv_stride_mode;
   logic [DATA_WIDTH-1:0] res_data;
   logic                  res_valid;
   logic                  res_ready;
   logic                  c_valid;
   logic                  c_ready;
   logic [DATA_WIDTH-1:0] psum_data;
   logic                  psum_valid;
   logic                  psum_ready;
   logic                  output_valid;
   logic [XW-1:0]         output_x;
   logic [YW-1:0]         output_y;
   logic [CW-1:0]         output_ch;
   logic                  running;
   logic                  done;

   modport master (
      output start, conv_stride_mode, res_data, res_valid, c_valid, psum_ready,
      input  res_ready, c_ready, psum_data, psum_valid, output_valid,
             output_x, output_y, output_ch, running, done
   );

   modport slave (
      input  start, conv_stride_mode, res_data, res_valid, c_valid, psum_ready,
      output res_ready, c_ready, psum_data, psum_valid, output_valid,
             output_x, output_y, output_ch, running, done
   );
endinterface

// File: rtl/conv_output_writer.sv
// Accelerator end of the shared C bus: buffers PE results, tags them with
// (x, y, ch) and bursts them onto the bus; between bursts the bus is released
// so the host can stream partial sums through to the accumulators.
module conv_output_writer #(
   parameter int DATA_WIDTH         = 16,
   parameter int FEATURE_MAP_WIDTH  = 128,
   parameter int FEATURE_MAP_HEIGHT = 128,
   parameter int OUTPUT_NB_CHANNELS = 64,
   parameter int FIFO_DEPTH         = 4
) (
   input  logic                  clk,
   input  logic                  arst,
   inout  wire  [DATA_WIDTH-1:0] c_input_output,
   conv_output_writer_if.slave   cw
);
   localparam int XW   = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1;
   localparam int YW   = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1;
   localparam int CW   = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1;
   localparam int PW   = $clog2(FIFO_DEPTH);
   localparam int CNTW = $clog2(FIFO_DEPTH + 1);
   localparam int TOTW = $clog2(FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS + 1);

   localparam logic [XW:0] W_FULL = (XW+1)'(FEATURE_MAP_WIDTH);
   localparam logic [YW:0] H_FULL = (YW+1)'(FEATURE_MAP_HEIGHT);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RX      = 3'd1;
   localparam logic [2:0] S_TURN_TX = 3'd2;
   localparam logic [2:0] S_TX      = 3'd3;
   localparam logic [2:0] S_TURN_RX = 3'd4;

   // Stride mode 11 is treated like 00 (no subsampling).
   function automatic logic [1:0] stride_shift(input logic [1:0] mode);
      case (mode)
         2'b01:   return 2'd1;
         2'b10:   return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

   logic [2:0]            state, state_nxt;
   logic [1:0]            shift;
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [CNTW-1:0]       count;
   logic [TOTW-1:0]       in_cnt;
   logic [XW-1:0]         x_cnt;
   logic [YW-1:0]         y_cnt;
   logic [CW-1:0]         ch_cnt;
   logic                  running_r, done_r, last_sent;

   logic [XW:0]           out_w;
   logic [YW:0]           out_h;
   logic [TOTW-1:0]       total;
   logic                  full, empty, active, push, pop;
   logic                  x_last, y_last, ch_last, last_word;

   assign out_w   = W_FULL >> shift;
   assign out_h   = H_FULL >> shift;
   assign total   = TOTW'(out_w) * TOTW'(out_h) * TOTW'(OUTPUT_NB_CHANNELS);

   assign full    = (count == CNTW'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign active  = (state != S_IDLE);
   // Stop accepting once the whole layer has been buffered.
   assign cw.res_ready = active && !full && (in_cnt < total);
   assign push    = cw.res_valid && cw.res_ready;
   assign pop     = (state == S_TX) && !empty;

   assign ch_last   = (ch_cnt == CW'(OUTPUT_NB_CHANNELS - 1));
   assign x_last    = ({1'b0, x_cnt} == out_w - 1'b1);
   assign y_last    = ({1'b0, y_cnt} == out_h - 1'b1);
   assign last_word = pop && ch_last && x_last && y_last;

   // Bus ownership follows the state register, so reset releases it at once.
   assign c_input_output  = (state == S_TX) ? mem[rd_ptr] : {DATA_WIDTH{1'bz}};
   assign cw.output_valid = (state == S_TX);
   assign cw.output_x     = x_cnt;
   assign cw.output_y     = y_cnt;
   assign cw.output_ch    = ch_cnt;
   assign cw.c_ready      = (state == S_RX) && cw.psum_ready;
   assign cw.psum_valid   = (state == S_RX) && cw.c_valid;
   assign cw.psum_data    = (state == S_RX) ? c_input_output : '0;
   assign cw.running      = running_r;
   assign cw.done         = done_r;

   // Next-state: leave RX when results wait and the host is idle or the buffer is full.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (cw.start) state_nxt = S_RX;
         S_RX:      if (!empty && (!cw.c_valid || full)) state_nxt = S_TURN_TX;
         S_TURN_TX: state_nxt = S_TX;
         S_TX:      if (count == CNTW'(1) && !push) state_nxt = S_TURN_RX;
         S_TURN_RX: state_nxt = last_sent ? S_IDLE : S_RX;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Control state: FSM, FIFO pointers, scan counters and layer status.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state     <= S_IDLE;
         shift     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         in_cnt    <= '0;
         x_cnt     <= '0;
         y_cnt     <= '0;
         ch_cnt    <= '0;
         running_r <= 1'b0;
         done_r    <= 1'b0;
         last_sent <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_r <= last_word;
         if (state == S_IDLE && cw.start) begin
            shift     <= stride_shift(cw.conv_stride_mode);
            in_cnt    <= '0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            ch_cnt    <= '0;
            running_r <= 1'b1;
            last_sent <= 1'b0;
         end
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            in_cnt <= in_cnt + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (ch_last) begin
               ch_cnt <= '0;
               if (x_last) begin
                  x_cnt <= '0;
                  y_cnt <= y_last ? '0 : y_cnt + 1'b1;
               end else begin
                  x_cnt <= x_cnt + 1'b1;
               end
            end else begin
               ch_cnt <= ch_cnt + 1'b1;
            end
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         if (last_word) begin
            running_r <= 1'b0;
            last_sent <= 1'b1;
         end
      end
   end

   // Result storage; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= cw.res_data;
   end
endmodule
